// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and instruction-fetch sequencer with branch redirect,
//            in-flight drop, fetch timeout and misaligned-target detection.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic [1:0]  br_op,
    input  logic [31:0] br_addr,
    input  logic        br_alu_zero,
    output logic        redirect,
    output logic        fetch_err
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [31:0]         r_pc, w_pc_next;
    logic [31:0]         r_addr, w_addr_next;
    logic [31:0]         r_instr, w_instr_next;
    logic [31:0]         r_instr_addr, w_instr_addr_next;
    logic                r_valid, w_valid_next;
    logic                r_redirect, w_redirect_next;
    logic                r_err, w_err_next;
    logic                r_drop, w_drop_next;
    logic                r_gap, w_gap_next;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_next;

    logic w_take;
    logic w_misaligned;
    logic w_req;

    assign w_take       = br_valid & ((br_op[0] & ~br_alu_zero) | (br_op[1] & br_alu_zero));
    assign w_misaligned = br_addr[1:0] != 2'b00;
    // r_gap marks the idle cycle after a discarded response
    assign w_req        = (r_state == S_REQ) & ~r_gap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_instr      <= 32'h0;
            r_instr_addr <= RESET_PC;
            r_valid      <= 1'b0;
            r_redirect   <= 1'b0;
            r_err        <= 1'b0;
            r_drop       <= 1'b0;
            r_gap        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_addr       <= w_addr_next;
            r_instr      <= w_instr_next;
            r_instr_addr <= w_instr_addr_next;
            r_valid      <= w_valid_next;
            r_redirect   <= w_redirect_next;
            r_err        <= w_err_next;
            r_drop       <= w_drop_next;
            r_gap        <= w_gap_next;
            r_cnt        <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_addr_next       = r_addr;
        w_instr_next      = r_instr;
        w_instr_addr_next = r_instr_addr;
        w_valid_next      = r_valid;
        w_redirect_next   = 1'b0;
        w_err_next        = r_err;
        w_drop_next       = r_drop;
        w_gap_next        = r_gap;
        w_cnt_next        = r_cnt;

        case (r_state)
            S_BOOT: w_state_next = S_REQ;
            S_REQ: begin
                if (w_req && imem_ack) begin
                    w_cnt_next = '0;
                    if (r_drop || w_take) begin
                        w_drop_next = 1'b0;
                        w_gap_next  = 1'b1;
                    end else begin
                        w_instr_next      = imem_rdata;
                        w_instr_addr_next = r_addr;
                        w_valid_next      = 1'b1;
                        w_state_next      = S_HOLD;
                    end
                end else if (w_req) begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                    if (w_take) begin
                        w_drop_next = 1'b1;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_ERR;
                    end
                end else begin
                    w_gap_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (r_valid && instr_ready) begin
                    w_pc_next    = r_pc + 32'd4;
                    w_valid_next = 1'b0;
                    w_state_next = S_REQ;
                end
            end
            default: ;
        endcase

        // A legal take overrides any sequential advance decided above
        if (w_take && (w_state_next != S_ERR)) begin
            if (w_misaligned) begin
                w_err_next   = 1'b1;
                w_state_next = S_ERR;
            end else begin
                w_pc_next       = br_addr;
                w_redirect_next = 1'b1;
                w_valid_next    = 1'b0;
                if (r_state == S_HOLD) begin
                    w_state_next = S_REQ;
                end
            end
        end

        if (w_state_next == S_ERR) begin
            w_valid_next = 1'b0;
            w_drop_next  = 1'b0;
            w_gap_next   = 1'b0;
            w_cnt_next   = '0;
        end

        // The request address only moves when no request is left outstanding
        if (!(w_req && !imem_ack)) begin
            w_addr_next = w_pc_next;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign instr_addr  = r_instr_addr;
    assign redirect    = r_redirect;
    assign fetch_err   = r_err;

endmodule
`default_nettype wire
